// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-path arbiter: one owner at a time, bursts of up to MAX_BURST words.
// ack is combinational, wr_req/data_in 1 cycle later; wfull stalls the owner with all state held.
module fifo_wr_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4,
    parameter int MAX_BURST  = 4
) (
    input  logic                          w_clk,
    input  logic                          wrst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic                          wfull,
    output logic [NUM_REQ-1:0]            grant,
    output logic [NUM_REQ-1:0]            ack,
    output logic                          wr_req,
    output logic [DATA_WIDTH-1:0]         data_in,
    output logic                          busy
);

    localparam int PW = $clog2(NUM_REQ);
    localparam int BW = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   own;
    logic [BW-1:0]   bcnt;

    logic            found;
    logic [PW-1:0]   sel;
    logic [PW:0]     cand;
    logic [DATA_WIDTH-1:0] own_dat;
    logic            own_req;
    logic            accept;
    logic            last;
    logic [PW-1:0]   ptr_after;

    // First asserted request at or after ptr, wrapping modulo NUM_REQ
    always_comb begin
        found = 1'b0;
        sel   = '0;
        cand  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, ptr} + (PW+1)'(i);
            if (cand >= (PW+1)'(NUM_REQ))
                cand = cand - (PW+1)'(NUM_REQ);
            if (!found && req[cand[PW-1:0]]) begin
                found = 1'b1;
                sel   = cand[PW-1:0];
            end
        end
    end

    always_comb begin
        own_dat = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (PW'(i) == own)
                own_dat = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign own_req   = req[own];
    assign accept    = (state == GRANT) && own_req && !wfull;
    assign last      = (bcnt == BW'(MAX_BURST - 1));
    assign ptr_after = (own == PW'(NUM_REQ - 1)) ? '0 : own + PW'(1);

    // grant is zero outside GRANT, so ack needs no state term
    assign ack  = grant & req & {NUM_REQ{~wfull}};
    assign busy = (state == GRANT);

    always_ff @(posedge w_clk or negedge wrst) begin
        if (!wrst) begin
            state   <= IDLE;
            grant   <= '0;
            ptr     <= '0;
            own     <= '0;
            bcnt    <= '0;
            wr_req  <= 1'b0;
            data_in <= '0;
        end else begin
            case (state)
                IDLE: begin
                    wr_req <= 1'b0;
                    if (found) begin
                        grant <= NUM_REQ'(1) << sel;
                        own   <= sel;
                        bcnt  <= '0;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    wr_req <= accept;
                    if (accept) begin
                        data_in <= own_dat;
                        bcnt    <= bcnt + BW'(1);
                    end
                    if (!own_req || (accept && last)) begin
                        grant <= '0;
                        ptr   <= ptr_after;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
